// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding and default sizing for mem_port_arbiter.
package mem_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_e;

  localparam int DEF_AW           = 32;
  localparam int DEF_DW           = 32;
  localparam int DEF_TIMEOUT      = 16;  // must be >= 2
  localparam int DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU fetch/data request ports plus the single memory port.
// slave  = arbiter view, master = pipeline + memory environment view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // instruction fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  // data port
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          bus_err;
  // memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_ack, if_rdata, dm_ack, dm_rdata, bus_err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_ack, if_rdata, dm_ack, dm_rdata, bus_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch (IF) and data (DM) ports.
// Fixed priority DM > IF, per-access bus watchdog that aborts with bus_err after TIMEOUT busy
// cycles. Optional IF starvation guard, enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
`ifdef MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
`endif
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] TO_MAX = WDW'(TIMEOUT);

  arb_state_e    state_q, state_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_we_q, mem_we_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          bus_err_q, bus_err_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic idle, busy, done, timed_out;
  logic if_elig, dm_elig, grant_if, grant_dm, force_if;

  assign idle      = (state_q == IDLE);
  assign busy      = !idle;
  assign done      = busy && bus.mem_ready;
  assign timed_out = busy && !bus.mem_ready && (wd_q == TO_MAX);

  // A requester whose ack is out this cycle has already been served; mask it.
  assign if_elig = bus.if_req && !if_ack_q;
  assign dm_elig = bus.dm_req && !dm_ack_q;

  // DM keeps its priority claim on the raw request, so a DM stream re-requesting in its own
  // ack cycle is not overtaken by a waiting fetch (only the guard can force IF through).
  assign grant_dm = idle && dm_elig && !force_if;
  assign grant_if = idle && if_elig && (force_if || !bus.dm_req);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

  logic [SCW-1:0] starve_q, starve_d;

  assign force_if = (starve_q == STARVE_MAX) && if_elig;

  // Count DM grants that pass over a waiting fetch; an IF grant clears the count.
  always_comb begin
    starve_d = starve_q;
    if (grant_if)
      starve_d = '0;
    else if (grant_dm && if_elig && (starve_q != STARVE_MAX))
      starve_d = starve_q + SCW'(1);
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`else
  assign force_if = 1'b0;
`endif

  // Arbitration, access sequencing and watchdog
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    wd_d        = wd_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (grant_dm) begin
          state_d     = BUSY_DM;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          mem_we_d    = bus.dm_we;
          wd_d        = WDW'(1);
        end else if (grant_if) begin
          state_d    = BUSY_IF;
          mem_addr_d = bus.if_addr;
          mem_we_d   = 1'b0;
          wd_d       = WDW'(1);
        end
      end
      BUSY_IF: begin
        if (done) begin
          state_d    = IDLE;
          if_ack_d   = 1'b1;
          if_rdata_d = bus.mem_rdata;
        end else if (timed_out) begin
          state_d    = IDLE;
          if_ack_d   = 1'b1;
          bus_err_d  = 1'b1;
          if_rdata_d = '0;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      BUSY_DM: begin
        if (done || timed_out) begin
          state_d   = IDLE;
          dm_ack_d  = 1'b1;
          bus_err_d = timed_out;
          mem_we_d  = 1'b0;
          // stores leave the load-data register untouched
          if (!mem_we_q) dm_rdata_d = timed_out ? '0 : bus.mem_rdata;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched access fields and registered responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.mem_en    = busy;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: transaction-level checks of mem_port_arbiter with random latencies/data.
// Build with MEM_ARB_STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = DEF_TIMEOUT;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SL = DEF_STARVE_LIMIT;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // One request from one port; memory answers in cycle lat of the access (lat=0: never).
  task automatic do_access(input logic is_dm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input int lat, input logic [31:0] rd);
    logic tmo;
    logic ok;
    int   n;
    tmo = (lat == 0);
    n   = tmo ? TO : lat;
    if (is_dm) begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      total++;
      if (bus.mem_en !== 1'b1 || bus.mem_addr !== addr || bus.mem_we !== (is_dm & we) ||
          bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0 || bus.bus_err !== 1'b0) begin
        bad++;
        $display("FAIL access_busy cyc=%0d: en=%b addr=%h we=%b ack=%b%b err=%b, want en=1 addr=%h we=%b ack=00 err=0",
                 i, bus.mem_en, bus.mem_addr, bus.mem_we, bus.if_ack, bus.dm_ack, bus.bus_err,
                 addr, is_dm & we);
      end
      if (is_dm && we) begin
        total++;
        if (bus.mem_wdata !== wdata) begin
          bad++;
          $display("FAIL access_wdata cyc=%0d: got %h want %h", i, bus.mem_wdata, wdata);
        end
      end
      bus.mem_ready = !tmo && (i == n);
      bus.mem_rdata = bus.mem_ready ? rd : $urandom;
    end
    @(negedge clk);
    bus.mem_ready = 1'b0;
    if (!is_dm) exp_if_rdata = tmo ? 32'h0 : rd;
    else if (!we) exp_dm_rdata = tmo ? 32'h0 : rd;
    total++;
    ok = (bus.bus_err === tmo) && (bus.mem_en === 1'b0);
    if (is_dm) ok = ok && bus.dm_ack === 1'b1 && bus.if_ack === 1'b0 && bus.dm_rdata === exp_dm_rdata;
    else       ok = ok && bus.if_ack === 1'b1 && bus.dm_ack === 1'b0 && bus.if_rdata === exp_if_rdata;
    if (!ok) begin
      bad++;
      $display("FAIL access_ack dm=%b lat=%0d: ack=%b%b err=%b en=%b if_rd=%h dm_rd=%h, want err=%b en=0 if_rd=%h dm_rd=%h",
               is_dm, lat, bus.if_ack, bus.dm_ack, bus.bus_err, bus.mem_en, bus.if_rdata,
               bus.dm_rdata, tmo, exp_if_rdata, exp_dm_rdata);
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_en !== 1'b0 || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0) begin
      bad++;
      $display("FAIL access_gap: en=%b ack=%b%b want all 0", bus.mem_en, bus.if_ack, bus.dm_ack);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.if_ack, bus.if_rdata, bus.dm_ack, bus.dm_rdata, bus.bus_err, bus.mem_en,
         bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: en=%b we=%b addr=%h wd=%h ack=%b%b err=%b, want all 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_ack, bus.dm_ack, bus.bus_err);
    end
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (bus.mem_en !== 1'b0 || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0 ||
          bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin
        bad++;
        $display("FAIL idle_ready_ignored: en=%b ack=%b%b if_rd=%h dm_rd=%h, want 0",
                 bus.mem_en, bus.if_ack, bus.dm_ack, bus.if_rdata, bus.dm_rdata);
      end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_single_fetch;
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 3, 32'h0050_0093);
  endtask

  task automatic test_collision;
    logic [31:0] r;
    r = $urandom;
    bus.if_req = 1'b1; bus.if_addr = 32'h80;
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h40; bus.dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL collision_dm_first: en=%b we=%b addr=%h wd=%h want 1 1 00000040 deadbeef",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = $urandom;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    total++;
    if (bus.dm_ack !== 1'b1 || bus.if_ack !== 1'b0 || bus.mem_en !== 1'b0 || bus.dm_rdata !== exp_dm_rdata) begin
      bad++;
      $display("FAIL collision_dm_ack: ack=%b%b en=%b dm_rd=%h want ack=01 en=0 dm_rd=%h",
               bus.if_ack, bus.dm_ack, bus.mem_en, bus.dm_rdata, exp_dm_rdata);
    end
    bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    @(negedge clk);
    total++;
    if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h80) begin
      bad++;
      $display("FAIL collision_if_next: en=%b we=%b addr=%h want 1 0 00000080",
               bus.mem_en, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = r;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    exp_if_rdata = r;
    total++;
    if (bus.if_ack !== 1'b1 || bus.dm_ack !== 1'b0 || bus.if_rdata !== exp_if_rdata) begin
      bad++;
      $display("FAIL collision_if_ack: ack=%b%b if_rd=%h want ack=10 if_rd=%h",
               bus.if_ack, bus.dm_ack, bus.if_rdata, exp_if_rdata);
    end
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    do_access(1'b1, 1'b0, 32'h300, 32'h0, TO, 32'hCAFE_0001);  // ready in last allowed cycle
    do_access(1'b1, 1'b0, 32'h304, 32'h0, 0, 32'h0);           // never ready: abort
    do_access(1'b0, 1'b0, 32'h308, 32'h0, 0, 32'h0);
    do_access(1'b1, 1'b0, 32'h30C, 32'h0, 1, 32'h1234_5678);
    do_access(1'b1, 1'b1, 32'h310, 32'h5555_AAAA, 2, 32'h0BAD_0BAD);  // store keeps dm_rdata
  endtask

  task automatic test_random;
    for (int k = 0; k < 30; k++) begin
      logic is_dm, we;
      int   lat;
      is_dm = 1'($urandom);
      we    = is_dm & 1'($urandom);
      lat   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      do_access(is_dm, we, $urandom, $urandom, lat, $urandom);
    end
  endtask

  task automatic test_no_double_grant;
    int bursts, acks, ack_c;
    logic prev;
    bursts = 0; acks = 0; ack_c = -1; prev = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h44;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.mem_en && !prev) bursts++;
      prev = bus.mem_en;
      if (bus.if_ack) begin acks++; ack_c = c; end
      if (ack_c >= 0 && c == ack_c + 1) bus.if_req = 1'b0;
      bus.mem_ready = bus.mem_en;
      bus.mem_rdata = $urandom;
    end
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    total++;
    if (bursts !== 1 || acks !== 1) begin
      bad++;
      $display("FAIL no_double_grant: bursts=%0d acks=%0d want 1 1", bursts, acks);
    end
    exp_if_rdata = bus.if_rdata;  // value is arbitrary random data; resync model only
  endtask

  task automatic test_starvation;
    int dm_n, if_n, first_if_after, c;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    dm_n = 0; if_n = 0; first_if_after = -1; c = 0;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h500;
    bus.if_req = 1'b1; bus.if_addr = 32'h600;
    while (c < 400 && dm_n < 50 && if_n == 0) begin
      @(negedge clk);
      c++;
      if (bus.dm_ack) dm_n++;
      if (bus.if_ack) begin if_n++; first_if_after = dm_n; end
      bus.mem_ready = bus.mem_en;
      bus.mem_rdata = $urandom;
    end
    bus.dm_req = 1'b0; bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    total++;
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (if_n !== 1 || first_if_after !== SL) begin
      bad++;
      $display("FAIL starve_guard: if_acks=%0d after %0d dm accesses, want 1 after %0d", if_n, first_if_after, SL);
    end
`else
    if (if_n !== 0 || dm_n !== 50) begin
      bad++;
      $display("FAIL starve_fixed_prio: if_acks=%0d dm_acks=%0d, want 0 and 50", if_n, dm_n);
    end
`endif
    repeat (3) @(negedge clk);
    total++;
    if (bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL starve_drain: en=%b want 0", bus.mem_en);
    end
    exp_if_rdata = bus.if_rdata; exp_dm_rdata = bus.dm_rdata;  // random data; resync model only
  endtask

  task automatic test_reset_mid_access;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200;
    @(negedge clk);
    total++;
    if (bus.mem_en !== 1'b1) begin
      bad++;
      $display("FAIL midreset_start: en=%b want 1", bus.mem_en);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (bus.mem_en !== 1'b0 || bus.dm_ack !== 1'b0 || bus.mem_addr !== 32'h0) begin
      bad++;
      $display("FAIL midreset_async: en=%b ack=%b addr=%h want 0 0 0", bus.mem_en, bus.dm_ack, bus.mem_addr);
    end
    bus.dm_req = 1'b0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.dm_ack !== 1'b0 || bus.mem_en !== 1'b0 || bus.dm_rdata !== 32'h0) begin
      bad++;
      $display("FAIL midreset_noack: ack=%b en=%b dm_rd=%h want 0 0 0", bus.dm_ack, bus.mem_en, bus.dm_rdata);
    end
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 2, 32'h7777_1111);
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    test_reset();
    test_single_fetch();
    test_collision();
    test_timeout();
    test_random();
    test_no_double_grant();
    test_starvation();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
